// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pkg
//  Description : Shared operation-mode encodings for the contador_param
//                counter family. Imported by contador_next and contador_param.
//  Contents    : MODE_UP_STEP (2'b00) count up by STEP
//                MODE_DOWN    (2'b01) count down by 1
//                MODE_UP      (2'b10) count up by 1
//                MODE_LOAD    (2'b11) synchronous parallel load
//  Revision    : 1.0 - initial release
// ============================================================================
package contador_pkg;

    localparam logic [1:0] MODE_UP_STEP = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_UP      = 2'b10;
    localparam logic [1:0] MODE_LOAD    = 2'b11;

endpackage : contador_pkg
`default_nettype wire

// File: rtl/contador_next.sv
`default_nettype none
// ============================================================================
//  Module      : contador_next
//  Description : Purely combinational next-state logic for contador_param.
//                Computes the next counter value and the next rco/load flags
//                from the current value, the operation mode and the wrap
//                point TOP.
//  Ports       : i_q      current counter value
//                i_mode   operation select (see contador_pkg)
//                i_enable count enable (does not gate loads)
//                i_d      parallel load value
//                i_top    highest legal count value
//                o_q      next counter value
//                o_rco    next ripple-carry-out flag
//                o_load   next load-done flag
//  Config      : CONTADOR_LIMIT_EN - when defined, TOP is a runtime value and
//                the wrap is decided by an explicit compare; otherwise TOP is
//                all-ones and the wrap is the carry out of the adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_next
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [1:0]       i_mode,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_top,
    output logic [WIDTH-1:0] o_q,
    output logic             o_rco,
    output logic             o_load
);

    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] c_one  = (WIDTH+1)'(1);

    // One WIDTH+1 bit adder serves both up modes; the extra bit keeps the
    // sum exact so the compare against TOP never sees a truncated value.
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_up_q;
    logic             w_up_wrap;

    assign w_inc = (i_mode == MODE_UP) ? c_one : c_step;
    assign w_sum = {1'b0, i_q} + w_inc;
    assign w_dec = i_q - WIDTH'(1);

`ifdef CONTADOR_LIMIT_EN
    logic [WIDTH:0] w_top_ext;
    logic [WIDTH:0] w_wrap_val;
    logic           w_above;

    assign w_top_ext  = {1'b0, i_top};
    assign w_wrap_val = w_sum - w_top_ext - c_one;
    // Q above TOP can only follow a load or a shrinking limit.
    assign w_above    = (i_q > i_top);

    always_comb begin
        w_up_q    = w_sum[WIDTH-1:0];
        w_up_wrap = 1'b0;
        if (w_above) begin
            // Out-of-range value recovers straight to zero.
            w_up_q    = '0;
            w_up_wrap = 1'b1;
        end else if (w_sum > w_top_ext) begin
            w_up_wrap = 1'b1;
            // A step larger than the whole range (small limit) would still
            // land above TOP after one fold; such a wrap settles at zero.
            if (w_wrap_val > w_top_ext) begin
                w_up_q = '0;
            end else begin
                w_up_q = w_wrap_val[WIDTH-1:0];
            end
        end
    end
`else
    // TOP is all-ones: wrapping is plain modulo-2^WIDTH arithmetic and the
    // wrap flag is simply the adder carry.
    assign w_up_q    = w_sum[WIDTH-1:0];
    assign w_up_wrap = w_sum[WIDTH];
`endif

    always_comb begin
        o_q    = i_q;
        o_rco  = 1'b0;
        o_load = 1'b0;
        case (i_mode)
            MODE_LOAD: begin
                o_q    = i_d;
                o_load = 1'b1;
            end
            MODE_DOWN: begin
                if (i_enable) begin
                    if (i_q == '0) begin
                        o_q   = i_top;
                        o_rco = 1'b1;
                    end else begin
                        o_q   = w_dec;
                    end
                end
            end
            default: begin
                // MODE_UP_STEP and MODE_UP share the adder path.
                if (i_enable) begin
                    o_q   = w_up_q;
                    o_rco = w_up_wrap;
                end
            end
        endcase
    end

endmodule : contador_next
`default_nettype wire

// File: rtl/contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : contador_param
//  Description : Parametrised synchronous counter with up-by-STEP, down-by-1,
//                up-by-1 and load modes, registered rco (wrap) and load-done
//                pulses. All outputs are flops; latency is one cycle.
//  Ports       : clk     rising-edge clock
//                reset   synchronous active-high reset
//                enable  count enable for the three count modes
//                mode    operation select (see contador_pkg)
//                D       parallel load value
//                limit   runtime wrap value (CONTADOR_LIMIT_EN only)
//                Q       counter value
//                rco     one-cycle pulse on wrap, aligned with Q
//                load    one-cycle pulse after a load, aligned with Q
//  Config      : CONTADOR_LIMIT_EN - adds the limit port; TOP follows it
//                combinationally. Otherwise TOP = 2^WIDTH-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_param
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
`ifdef CONTADOR_LIMIT_EN
    input  logic [WIDTH-1:0] limit,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic             r_load;

    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_q_next;
    logic             w_rco_next;
    logic             w_load_next;

`ifdef CONTADOR_LIMIT_EN
    assign w_top = limit;
`else
    assign w_top = '1;
`endif

    contador_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .i_q      (r_q),
        .i_mode   (mode),
        .i_enable (enable),
        .i_d      (D),
        .i_top    (w_top),
        .o_q      (w_q_next),
        .o_rco    (w_rco_next),
        .o_load   (w_load_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_rco  <= 1'b0;
            r_load <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_rco  <= w_rco_next;
            r_load <= w_load_next;
        end
    end

    assign Q    = r_q;
    assign rco  = r_rco;
    assign load = r_load;

endmodule : contador_param
`default_nettype wire

// File: tb/tb_contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_param
//  Description : Self-checking bench for contador_param (WIDTH=4, STEP=3).
//                A driver issues directed vectors and queues the expected
//                Q/rco/load; an independent monitor pops and compares one
//                entry after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_param;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] D;
`ifdef CONTADOR_LIMIT_EN
    logic [3:0] limit_s;
`endif
    logic [3:0] Q;
    logic       rco;
    logic       load;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    logic [3:0] exp_q_q[$];
    logic       exp_rco_q[$];
    logic       exp_load_q[$];
    string      exp_tag_q[$];

    contador_param #(
        .WIDTH (4),
        .STEP  (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .D      (D),
`ifdef CONTADOR_LIMIT_EN
        .limit  (limit_s),
`endif
        .Q      (Q),
        .rco    (rco),
        .load   (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue what the DUT must show after the
    // next rising edge, then move to the following falling edge.
    task automatic step(input logic r, input logic en, input logic [1:0] md,
                        input logic [3:0] d, input logic [3:0] eq,
                        input logic erco, input logic eload, input string tag);
        reset  = r;
        enable = en;
        mode   = md;
        D      = d;
        exp_q_q.push_back(eq);
        exp_rco_q.push_back(erco);
        exp_load_q.push_back(eload);
        exp_tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Monitor: every output sample is compared against the oldest entry.
    initial begin
        logic [3:0] eq;
        logic       erco;
        logic       eload;
        string      tag;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_q.size() > 0) begin
                eq    = exp_q_q.pop_front();
                erco  = exp_rco_q.pop_front();
                eload = exp_load_q.pop_front();
                tag   = exp_tag_q.pop_front();
                checks++;
                if (Q !== eq) begin
                    errors++;
                    $display("FAIL %s Q: got %0d expected %0d", tag, Q, eq);
                end
                checks++;
                if (rco !== erco) begin
                    errors++;
                    $display("FAIL %s rco: got %b expected %b", tag, rco, erco);
                end
                checks++;
                if (load !== eload) begin
                    errors++;
                    $display("FAIL %s load: got %b expected %b", tag, load, eload);
                end
            end
        end
    end

    initial begin
`ifdef CONTADOR_LIMIT_EN
        limit_s = 4'd15;
`endif
        // Reset held with counting requested.
        step(1, 1, 2'b10, 4'd0,  4'd0,  0, 0, "reset0");
        step(1, 1, 2'b10, 4'd0,  4'd0,  0, 0, "reset1");
        step(1, 1, 2'b10, 4'd0,  4'd0,  0, 0, "reset2");

        // Up by STEP across the wrap.
        step(0, 0, 2'b11, 4'd14, 4'd14, 0, 1, "load14");
        step(0, 1, 2'b00, 4'd0,  4'd1,  1, 0, "step_wrap");
        step(0, 1, 2'b00, 4'd0,  4'd4,  0, 0, "step_plain");

        // Down by 1 across zero.
        step(0, 1, 2'b11, 4'd0,  4'd0,  0, 1, "load0_en");
        step(0, 1, 2'b01, 4'd0,  4'd15, 1, 0, "down_wrap");
        step(0, 1, 2'b01, 4'd0,  4'd14, 0, 0, "down_plain");

        // Load with enable low, then hold.
        step(0, 0, 2'b11, 4'd9,  4'd9,  0, 1, "load9");
        step(0, 0, 2'b10, 4'd3,  4'd9,  0, 0, "hold");

        // Disable after a wrap clears rco; step wrap from 15.
        step(0, 1, 2'b11, 4'd0,  4'd0,  0, 1, "load0b");
        step(0, 1, 2'b01, 4'd0,  4'd15, 1, 0, "down_wrap2");
        step(0, 0, 2'b01, 4'd0,  4'd15, 0, 0, "hold_clr_rco");
        step(0, 1, 2'b00, 4'd0,  4'd2,  1, 0, "step_wrap15");
        step(0, 1, 2'b10, 4'd0,  4'd3,  0, 0, "up1");

        // Reset wins over a wrap on the same edge.
        step(0, 0, 2'b11, 4'd15, 4'd15, 0, 1, "load15");
        step(1, 1, 2'b10, 4'd0,  4'd0,  0, 0, "reset_on_wrap");
        step(0, 1, 2'b10, 4'd0,  4'd1,  0, 0, "after_reset");

`ifdef CONTADOR_LIMIT_EN
        limit_s = 4'd9;
        step(0, 0, 2'b11, 4'd8,  4'd8,  0, 1, "lim_load8");
        step(0, 1, 2'b10, 4'd0,  4'd9,  0, 0, "lim_up_to9");
        step(0, 1, 2'b10, 4'd0,  4'd0,  1, 0, "lim_up_wrap");
        step(0, 0, 2'b11, 4'd8,  4'd8,  0, 1, "lim_load8b");
        step(0, 1, 2'b00, 4'd0,  4'd1,  1, 0, "lim_step_wrap");
        step(0, 0, 2'b11, 4'd12, 4'd12, 0, 1, "lim_load12");
        step(0, 1, 2'b10, 4'd0,  4'd0,  1, 0, "lim_above_up");
        step(0, 0, 2'b11, 4'd12, 4'd12, 0, 1, "lim_load12b");
        step(0, 1, 2'b01, 4'd0,  4'd11, 0, 0, "lim_above_down");
        limit_s = 4'd0;
        step(0, 0, 2'b11, 4'd0,  4'd0,  0, 1, "lim0_load0");
        step(0, 1, 2'b10, 4'd0,  4'd0,  1, 0, "lim0_up_a");
        step(0, 1, 2'b10, 4'd0,  4'd0,  1, 0, "lim0_up_b");
        step(0, 1, 2'b01, 4'd0,  4'd0,  1, 0, "lim0_down");
`endif

        // Idle cycles let the monitor drain the queue.
        step(0, 0, 2'b10, 4'd0,  Q,     0, 0, "idle_hold");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule : tb_contador_param
`default_nettype wire

// File: doc/contador_param.md
# contador_param

Parametrised synchronous counter for the 4-bit counter lineage. It supports up-by-STEP, down-by-1, up-by-1 and synchronous-load modes at any width, with registered ripple-carry-out (`rco`) and load-done (`load`) flags. An optional runtime count limit replaces the natural 2^WIDTH wrap point. It is a leaf block that drives `Q` straight to the datapath or to the next counter stage.

## Interface
- `WIDTH`, default 4: counter width in bits, ≥2.
- `STEP`, default 3: increment for mode 00, range 1..2^WIDTH-1.
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- `enable`  input  1  count enable; gates modes 00/01/10 only.
- `mode`  input  2  operation select (see Operation).
- `D`  input  WIDTH  parallel load value.
- `limit`  input  WIDTH  wrap value; present only with `CONTADOR_LIMIT_EN`.
- `Q`  output  WIDTH  counter value, registered.
- `rco`  output  1  registered one-cycle pulse on wrap.
- `load`  output  1  registered one-cycle pulse after a load.

## Operation
- TOP is `limit` when `CONTADOR_LIMIT_EN` is defined, otherwise 2^WIDTH-1. The count range is 0..TOP (TOP+1 states).
- Reset: `Q`=0, `rco`=0, `load`=0. Reset overrides every other input, including a wrap or load in the same cycle.
- Mode 00, up by STEP, when `enable`=1:
  - If Q+STEP ≤ TOP: Q←Q+STEP, `rco`←0.
  - Otherwise: Q←Q+STEP-TOP-1, `rco`←1.
  - The sum is computed at WIDTH+1 bits, so there is no truncation before the compare.
- Mode 01, down by 1, when `enable`=1:
  - If Q=0: Q←TOP, `rco`←1.
  - Otherwise: Q←Q-1, `rco`←0.
- Mode 10, up by 1: the same as mode 00 with a step of 1.
- Mode 11, load: Q←D, `load`←1, `rco`←0. Load ignores `enable`.
- When `enable`=0 in modes 00/01/10: Q holds, and `rco` and `load` are cleared.
- `load` is cleared in every cycle that is not a load.
- Q>TOP can only arise from a load or from a change to `limit`:
  - An up count from Q>TOP produces Q←0 with `rco`=1.
  - A down count from Q>TOP produces Q←Q-1 with `rco`=0.
- `limit`=0: every enabled count leaves Q=0 with `rco`=1.
- `mode`, `D` and `limit` may change on any cycle. Only the values sampled at the clock edge matter.

## Timing
- Every output is a flop; there is no combinational path from input to output.
- Latency is one cycle: inputs sampled at edge n appear on `Q`/`rco`/`load` after edge n.
- `rco` and `load` are aligned with the `Q` value they describe. Each lasts exactly one cycle per event.
- Back-to-back wraps (for example `limit`=0, or down-counting with TOP=0) hold `rco` high for consecutive cycles.
- The next-state logic is one adder/subtractor of WIDTH+1 bits plus a comparator. It must meet timing at WIDTH=16.

## Configuration
- `CONTADOR_LIMIT_EN` defined:
  - The `limit` input port exists.
  - TOP follows `limit` every cycle, with no extra register stage.
- `CONTADOR_LIMIT_EN` undefined:
  - The `limit` port is absent.
  - TOP is the constant 2^WIDTH-1, and the wrap reduces to natural modulo-2^WIDTH arithmetic.
  - The compare logic is removed.

## Structure
- Package `contador_pkg` holds the mode constants: `MODE_UP_STEP`=2'b00, `MODE_DOWN`=2'b01, `MODE_UP`=2'b10, `MODE_LOAD`=2'b11.
- One combinational sub-module, `contador_next`:
  - Inputs: Q, mode, enable, D, TOP.
  - Outputs: next Q, next `rco`, next `load`.
- The top level holds only the registers and the reset mux.

## Test plan
Unless stated, WIDTH=4 and STEP=3.
- Reset: hold `reset`=1 with `enable`=1 and mode 10 for 3 cycles → Q=0, `rco`=0, `load`=0 throughout.
- Mode 00, `enable`=1, from Q=14 → Q=1 with `rco`=1, then Q=4 with `rco`=0.
- Mode 01, `enable`=1, from Q=0 → Q=15 with `rco`=1, then Q=14 with `rco`=0.
- Mode 11 with D=9 and `enable`=0 → Q=9 and `load`=1 for one cycle. Then mode 10 with `enable`=0 → Q stays 9 and `load`=0.
- With `CONTADOR_LIMIT_EN` and `limit`=9:
  - Mode 10 from 8 → 9, then 0 with `rco`=1.
  - Mode 00 from 8 → 1 with `rco`=1.
  - Load 12, then mode 10 → 0 with `rco`=1.
- Mode 10 at Q=15 with `reset`=1 on the wrap edge → Q=0, `rco`=0. On the next cycle with `reset`=0 → Q=1.
